// File: rtl/mode_button_debounce.sv
// Debounces the raw active-low mode pushbutton on slow sample ticks and emits
// clean press, release and long-press strobes in the clk domain.
module mode_button_debounce #(
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned LONG_TICKS     = 10000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic mode_button,
  output logic pressed,
  output logic press_strobe,
  output logic release_strobe,
  output logic long_press
);

  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_SAMPLES);
  localparam logic [15:0] LONG_MAX   = 16'(LONG_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_HELD
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        tick_d;
  logic [7:0]  stab_cnt;
  logic [15:0] hold_cnt;

  logic        sample;
  logic        tick_rise;
  logic [7:0]  stab_inc;
  logic [15:0] hold_inc;

  assign sample    = ~sync2;
  assign tick_rise = sample_tick & ~tick_d;
  assign stab_inc  = stab_cnt + 8'd1;
  assign hold_inc  = hold_cnt + 16'd1;

  // Synchroniser idles high so a button held through reset reads as released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      tick_d <= 1'b0;
    end else begin
      sync1  <= mode_button;
      sync2  <= sync1;
      tick_d <= sample_tick;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      stab_cnt       <= 8'd0;
      hold_cnt       <= 16'd0;
      pressed        <= 1'b0;
      press_strobe   <= 1'b0;
      release_strobe <= 1'b0;
      long_press     <= 1'b0;
    end else begin
      press_strobe   <= 1'b0;
      release_strobe <= 1'b0;
      long_press     <= 1'b0;
      if (tick_rise) begin
        case (state)
          IDLE: begin
            if (sample) begin
              if (stab_inc == STABLE_MAX) begin
                state        <= HELD;
                pressed      <= 1'b1;
                stab_cnt     <= 8'd0;
                hold_cnt     <= 16'd0;
                press_strobe <= 1'b1;
              end else begin
                stab_cnt <= stab_inc;
              end
            end else begin
              stab_cnt <= 8'd0;
            end
          end
          HELD, LONG_HELD: begin
            // hold_cnt stays below LONG_MAX while HELD, so it can never wrap.
            if (!sample) begin
              if (stab_inc == STABLE_MAX) begin
                state          <= IDLE;
                pressed        <= 1'b0;
                stab_cnt       <= 8'd0;
                release_strobe <= 1'b1;
              end else begin
                stab_cnt <= stab_inc;
              end
            end else begin
              stab_cnt <= 8'd0;
              if (state == HELD) begin
                hold_cnt <= hold_inc;
                if (hold_inc == LONG_MAX) begin
                  state      <= LONG_HELD;
                  long_press <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_button_debounce.sv
// Directed bench for mode_button_debounce with STABLE_SAMPLES=4, LONG_TICKS=20
// and a one-clock sample tick every eight clocks.
module tb_mode_button_debounce;

  logic clk;
  logic reset_n;
  logic sample_tick;
  logic mode_button;
  logic pressed;
  logic press_strobe;
  logic release_strobe;
  logic long_press;

  int checks;
  int errors;
  int press_seen;
  int release_seen;
  int long_seen;

  mode_button_debounce #(
    .STABLE_SAMPLES(4),
    .LONG_TICKS(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_tick(sample_tick),
    .mode_button(mode_button),
    .pressed(pressed),
    .press_strobe(press_strobe),
    .release_strobe(release_strobe),
    .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe tallies, sampled mid-cycle so each one-clock strobe counts once.
  initial begin
    press_seen   = 0;
    release_seen = 0;
    long_seen    = 0;
  end
  always @(negedge clk) begin
    if (press_strobe === 1'b1) press_seen++;
    if (release_strobe === 1'b1) release_seen++;
    if (long_press === 1'b1) long_seen++;
  end

  // Seven low clocks then one high clock; returns just after the sampling edge.
  task automatic do_tick();
    repeat (7) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic do_reset(input logic btn);
    reset_n     = 1'b0;
    mode_button = btn;
    sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    mode_button = 1'b0;
    sample_tick = 1'b0;
    do_tick();
    do_tick();
    checks++;
    if ({pressed, press_strobe, release_strobe, long_press} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000",
               {pressed, press_strobe, release_strobe, long_press});
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      checks++;
      if (press_strobe !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL reset_press_strobe tick %0d: got %b expected %b", k, press_strobe, (k == 4));
      end
      checks++;
      if (pressed !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL reset_pressed tick %0d: got %b expected %b", k, pressed, (k == 4));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({pressed, press_strobe} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_strobe_width: got %b expected 10", {pressed, press_strobe});
    end
  endtask

  task automatic test_clean_press();
    int p0, r0, l0;
    do_reset(1'b1);
    p0 = press_seen;
    r0 = release_seen;
    l0 = long_seen;
    mode_button = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      do_tick();
      checks++;
      if (press_strobe !== (k == 4) || pressed !== (k >= 4)) begin
        errors++;
        $display("[TB] FAIL clean_press tick %0d: got strobe=%b pressed=%b expected strobe=%b pressed=%b",
                 k, press_strobe, pressed, (k == 4), (k >= 4));
      end
    end
    mode_button = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      do_tick();
      checks++;
      if (release_strobe !== (k == 4) || pressed !== (k < 4)) begin
        errors++;
        $display("[TB] FAIL clean_release tick %0d: got strobe=%b pressed=%b expected strobe=%b pressed=%b",
                 k, release_strobe, pressed, (k == 4), (k < 4));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (press_seen - p0 != 1 || release_seen - r0 != 1 || long_seen - l0 != 0) begin
      errors++;
      $display("[TB] FAIL clean_counts: got press=%0d release=%0d long=%0d expected 1 1 0",
               press_seen - p0, release_seen - r0, long_seen - l0);
    end
  endtask

  task automatic test_bounce();
    logic [10:0] pattern;
    int p0;
    // Raw levels in tick order, bit 10 first: 3 pressed, 1 released, 3 pressed, 4 released.
    pattern = 11'b000_1_000_1111;
    do_reset(1'b1);
    p0 = press_seen;
    for (int k = 10; k >= 0; k--) begin
      mode_button = pattern[k];
      do_tick();
      checks++;
      if (pressed !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_pressed step %0d: got %b expected 0", 10 - k, pressed);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (press_seen - p0 != 0) begin
      errors++;
      $display("[TB] FAIL bounce_strobes: got %0d expected 0", press_seen - p0);
    end
  endtask

  task automatic test_long_press();
    int l0, r0;
    do_reset(1'b1);
    l0 = long_seen;
    mode_button = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      do_tick();
      checks++;
      if (press_strobe !== (k == 4) || long_press !== (k == 24)) begin
        errors++;
        $display("[TB] FAIL long_hold tick %0d: got press=%b long=%b expected press=%b long=%b",
                 k, press_strobe, long_press, (k == 4), (k == 24));
      end
    end
    repeat (2) @(negedge clk);
    r0 = release_seen;
    checks++;
    if (long_seen - l0 != 1) begin
      errors++;
      $display("[TB] FAIL long_count: got %0d expected 1", long_seen - l0);
    end
    mode_button = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      checks++;
      if (release_strobe !== (k == 4) || pressed !== (k < 4) || long_press !== 1'b0) begin
        errors++;
        $display("[TB] FAIL long_release tick %0d: got rel=%b pressed=%b long=%b expected rel=%b pressed=%b long=0",
                 k, release_strobe, pressed, long_press, (k == 4), (k < 4));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (release_seen - r0 != 1) begin
      errors++;
      $display("[TB] FAIL long_release_count: got %0d expected 1", release_seen - r0);
    end
  endtask

  task automatic test_reset_in_long();
    do_reset(1'b1);
    mode_button = 1'b0;
    for (int k = 1; k <= 25; k++) do_tick();
    checks++;
    if (pressed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL long_state_pressed: got %b expected 1", pressed);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pressed, press_strobe, release_strobe, long_press} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected 0000",
               {pressed, press_strobe, release_strobe, long_press});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      do_tick();
      checks++;
      if (press_strobe !== (k == 4) || long_press !== (k == 24) || pressed !== (k >= 4)) begin
        errors++;
        $display("[TB] FAIL rearm tick %0d: got press=%b long=%b pressed=%b expected press=%b long=%b pressed=%b",
                 k, press_strobe, long_press, pressed, (k == 4), (k == 24), (k >= 4));
      end
    end
  endtask

  task automatic test_tick_stuck_high();
    int p0;
    do_reset(1'b1);
    mode_button = 1'b0;
    repeat (4) @(posedge clk);
    p0 = press_seen;
    #1 sample_tick = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (pressed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stuck_tick_pressed: got %b expected 0", pressed);
    end
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (press_seen - p0 != 0) begin
      errors++;
      $display("[TB] FAIL stuck_tick_strobes: got %0d expected 0", press_seen - p0);
    end
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      checks++;
      if (press_strobe !== (k == 3) || pressed !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL stuck_tick_followup tick %0d: got strobe=%b pressed=%b expected %b %b",
                 k, press_strobe, pressed, (k == 3), (k == 3));
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    mode_button = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_reset_in_long();
    test_tick_stuck_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
